// File: rtl/mips_defs.sv
// Shared definitions for the execute-stage multiply/divide unit:
// op encodings, FSM state encoding and default datapath width.
package mips_defs;

    localparam int MD_WIDTH = 32;

    typedef enum logic [1:0] {
        MD_MULTU = 2'b00,
        MD_MULT  = 2'b01,
        MD_DIVU  = 2'b10,
        MD_DIV   = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'b00,
        MD_CALC = 2'b01,
        MD_FIX  = 2'b10
    } md_state_e;

    function automatic logic md_is_div(input md_op_e op);
        return (op == MD_DIVU) || (op == MD_DIV);
    endfunction

    function automatic logic md_is_signed(input md_op_e op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage

// File: rtl/md_abs_neg.sv
// Conditional two's-complement negate: used to take operand magnitudes
// and to restore result signs after the unsigned iteration.
module md_abs_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] val,
    input  logic         neg,
    output logic [W-1:0] res
);

    assign res = neg ? (~val + {{(W-1){1'b0}}, 1'b1}) : val;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Works on magnitudes for WIDTH cycles, then fixes signs and writes HI/LO.
module mult_div_unit
    import mips_defs::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] MD_srca,
    input  logic [WIDTH-1:0] MD_srcb,
    input  logic [1:0]       MD_op,
    input  logic             MD_start,
    input  logic             MD_wr_hi,
    input  logic             MD_wr_lo,
    input  logic [WIDTH-1:0] MD_wdata,
    output logic             MD_busy,
    output logic             MD_done,
    output logic             MD_dz,
    output logic [WIDTH-1:0] MD_hi,
    output logic [WIDTH-1:0] MD_lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    md_state_e          state_q, state_d;
    md_op_e             op_q, op_d, op_in;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   r_q, r_d, l_q, l_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               ps_q, ps_d, rs_q, rs_d;
    logic               dz_q, dz_d, done_q, done_d;

    logic               in_signed, sa, sb, last_iter, div_ge;
    logic [WIDTH-1:0]   abs_a, abs_b, q_fix, r_fix, sub;
    logic [2*WIDTH-1:0] p_fix;
    logic [WIDTH:0]     mul_sum, trial;

    assign op_in     = md_op_e'(MD_op);
    assign in_signed = md_is_signed(op_in);
    assign sa        = in_signed & MD_srca[WIDTH-1];
    assign sb        = in_signed & MD_srcb[WIDTH-1];
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    md_abs_neg #(.W(WIDTH))   u_abs_a (.val(MD_srca),    .neg(sa),   .res(abs_a));
    md_abs_neg #(.W(WIDTH))   u_abs_b (.val(MD_srcb),    .neg(sb),   .res(abs_b));
    md_abs_neg #(.W(2*WIDTH)) u_fix_p (.val({r_q, l_q}), .neg(ps_q), .res(p_fix));
    md_abs_neg #(.W(WIDTH))   u_fix_q (.val(l_q),        .neg(ps_q), .res(q_fix));
    md_abs_neg #(.W(WIDTH))   u_fix_r (.val(r_q),        .neg(rs_q), .res(r_fix));

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state_q <= MD_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            MD_IDLE: if (MD_start) state_d = MD_CALC;
            MD_CALC: if (last_iter) state_d = MD_FIX;
            MD_FIX:  state_d = MD_IDLE;
            default: state_d = MD_IDLE;
        endcase
    end

    always_comb begin
        MD_busy = (state_q != MD_IDLE);
    end

    // r:l is the product shift pair for multiply, remainder:dividend for divide.
    always_comb begin
        op_d   = op_q;
        cnt_d  = cnt_q;
        a_d    = a_q;
        b_d    = b_q;
        r_d    = r_q;
        l_d    = l_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        ps_d   = ps_q;
        rs_d   = rs_q;
        dz_d   = dz_q;
        done_d = 1'b0;

        mul_sum = {1'b0, r_q} + ({1'b0, a_q} & {(WIDTH+1){l_q[0]}});
        trial   = {r_q, l_q[WIDTH-1]};
        div_ge  = (trial >= {1'b0, b_q});
        sub     = trial[WIDTH-1:0] - b_q;

        case (state_q)
            MD_IDLE: begin
                if (MD_wr_hi) hi_d = MD_wdata;
                if (MD_wr_lo) lo_d = MD_wdata;
                if (MD_start) begin
                    op_d  = op_in;
                    a_d   = abs_a;
                    b_d   = abs_b;
                    r_d   = '0;
                    l_d   = md_is_div(op_in) ? abs_a : abs_b;
                    cnt_d = '0;
                    dz_d  = md_is_div(op_in) && (MD_srcb == '0);
                    // Divide-by-zero keeps the all-ones quotient unnegated.
                    ps_d  = (sa ^ sb) & ~dz_d;
                    rs_d  = sa;
                end
            end
            MD_CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (md_is_div(op_q)) begin
                    r_d = div_ge ? sub : trial[WIDTH-1:0];
                    l_d = {l_q[WIDTH-2:0], div_ge};
                end else begin
                    r_d = mul_sum[WIDTH:1];
                    l_d = {mul_sum[0], l_q[WIDTH-1:1]};
                end
            end
            MD_FIX: begin
                done_d = 1'b1;
                if (md_is_div(op_q)) {hi_d, lo_d} = {r_fix, q_fix};
                else                 {hi_d, lo_d} = p_fix;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            op_q   <= MD_MULTU;
            cnt_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            r_q    <= '0;
            l_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            ps_q   <= 1'b0;
            rs_q   <= 1'b0;
            dz_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            op_q   <= op_d;
            cnt_q  <= cnt_d;
            a_q    <= a_d;
            b_q    <= b_d;
            r_q    <= r_d;
            l_q    <= l_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            ps_q   <= ps_d;
            rs_q   <= rs_d;
            dz_q   <= dz_d;
            done_q <= done_d;
        end
    end

    assign MD_done = done_q;
    assign MD_dz   = dz_q;
    assign MD_hi   = hi_q;
    assign MD_lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed corner cases plus
// random ops against a plain-arithmetic HI/LO reference model.
module tb_mult_div_unit;

    localparam int W = 32;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic [W-1:0] srca = '0, srcb = '0, wdata = '0;
    logic [1:0]   op = 2'b00;
    logic         start = 1'b0, wr_hi = 1'b0, wr_lo = 1'b0;
    logic         busy, done, dz;
    logic [W-1:0] hi, lo;

    int           n_chk = 0;
    int           n_err = 0;
    logic [W-1:0] exp_hi = '0, exp_lo = '0;

    mult_div_unit #(.WIDTH(W)) dut (
        .CLK(CLK), .RST(RST),
        .MD_srca(srca), .MD_srcb(srcb), .MD_op(op), .MD_start(start),
        .MD_wr_hi(wr_hi), .MD_wr_lo(wr_lo), .MD_wdata(wdata),
        .MD_busy(busy), .MD_done(done), .MD_dz(dz),
        .MD_hi(hi), .MD_lo(lo)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    // Returns {HI, LO} from the architectural definition of each op.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, rm;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (o)
            2'b00: r = {32'd0, a} * {32'd0, b};
            2'b01: r = sa * sb;
            2'b10: r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            default: begin
                if (b == 0) r = {a, 32'hFFFF_FFFF};
                else begin
                    q  = sa / sb;
                    rm = sa % sb;
                    r  = {rm[31:0], q[31:0]};
                end
            end
        endcase
        return r;
    endfunction

    // Caller sits #1 after the accept edge; lat = edges until done seen (0 = timeout).
    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge CLK); #1;
            if (done) begin lat = i; break; end
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit now, input string tag);
        logic [63:0] m;
        int lat, bcnt;
        m = model(o, a, b);
        if (!now) @(negedge CLK);
        op = o; srca = a; srcb = b; start = 1'b1;
        @(posedge CLK); #1;
        start = 1'b0; srca = $urandom; srcb = $urandom;
        bcnt = busy ? 1 : 0;
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge CLK); #1;
            if (done) begin lat = i; break; end
            if (busy) bcnt++;
        end
        chk({tag, ".lat"},  64'(lat),  64'd33);
        chk({tag, ".busy"}, 64'(bcnt), 64'd33);
        chk({tag, ".hi"},   64'(hi),   64'(m[63:32]));
        chk({tag, ".lo"},   64'(lo),   64'(m[31:0]));
        if (o[1]) chk({tag, ".dz"}, 64'(dz), 64'(b == 0));
        exp_hi = m[63:32];
        exp_lo = m[31:0];
    endtask

    initial begin
        int lat, dones;
        logic [63:0] m;
        logic [1:0]  ro;
        logic [W-1:0] ra, rb;

        repeat (3) @(posedge CLK);
        #1;
        chk("rst.hi", 64'(hi), 0);
        chk("rst.lo", 64'(lo), 0);
        chk("rst.busy", 64'(busy), 0);
        chk("rst.done", 64'(done), 0);
        chk("rst.dz", 64'(dz), 0);
        @(negedge CLK); RST = 1'b1;

        // MTHI in idle
        @(negedge CLK); wdata = 32'h1234; wr_hi = 1'b1;
        @(posedge CLK); #1; wr_hi = 1'b0;
        chk("mthi.hi", 64'(hi), 64'h1234);
        chk("mthi.lo", 64'(lo), 0);

        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
        chk("multu_max.const", {32'(hi), 32'(lo)}, 64'hFFFF_FFFE_0000_0001);
        run_op(2'b01, -32'sd3, 32'd7, 1'b0, "mult_neg");
        chk("mult_neg.const", {32'(hi), 32'(lo)}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0, "mult_minmin");
        run_op(2'b10, 32'd100, 32'd7, 1'b0, "divu");
        run_op(2'b11, -32'sd7, 32'd2, 1'b0, "div_nd");
        run_op(2'b11, 32'd7, -32'sd2, 1'b0, "div_dn");
        run_op(2'b11, 32'd5, 32'd0, 1'b0, "div_z");
        chk("div_z.const", {32'(hi), 32'(lo)}, 64'h0000_0005_FFFF_FFFF);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_ovf");
        run_op(2'b10, 32'hDEAD_BEEF, 32'd0, 1'b1, "divu_z");
        run_op(2'b11, -32'sd9, 32'd0, 1'b1, "div_negz");

        // start re-pulsed while busy must be ignored
        m = model(2'b00, 32'd1000, 32'd1000);
        @(negedge CLK); op = 2'b00; srca = 32'd1000; srcb = 32'd1000; start = 1'b1;
        @(posedge CLK); #1; start = 1'b0;
        dones = 0; lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge CLK); #1;
            if (done) begin dones++; if (lat == 0) lat = i; end
            if (i == 5) begin op = 2'b11; srca = 32'd7; srcb = 32'd3; start = 1'b1; end
            if (i == 6) start = 1'b0;
        end
        chk("rebusy.dones", 64'(dones), 1);
        chk("rebusy.lat", 64'(lat), 33);
        chk("rebusy.lo", 64'(lo), 64'(m[31:0]));
        exp_hi = m[63:32]; exp_lo = m[31:0];

        // MTLO while busy is dropped
        m = model(2'b00, 32'd3, 32'd5);
        @(negedge CLK); op = 2'b00; srca = 32'd3; srcb = 32'd5; start = 1'b1;
        @(posedge CLK); #1; start = 1'b0;
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge CLK); #1;
            if (done) begin lat = i; break; end
            if (i == 3) begin wdata = 32'hDEAD; wr_lo = 1'b1; end
            if (i == 4) wr_lo = 1'b0;
            if (i == 10) chk("mtlo_busy.lo", 64'(lo), 64'(exp_lo));
        end
        chk("mtlo_busy.lat", 64'(lat), 33);
        chk("mtlo_busy.res", 64'(lo), 64'(m[31:0]));

        // write together with start: write lands, then result overwrites
        m = model(2'b10, 32'd50, 32'd8);
        @(negedge CLK); wdata = 32'hABCD; wr_hi = 1'b1;
        op = 2'b10; srca = 32'd50; srcb = 32'd8; start = 1'b1;
        @(posedge CLK); #1; wr_hi = 1'b0; start = 1'b0;
        chk("wrstart.hi_now", 64'(hi), 64'hABCD);
        wait_done(lat);
        chk("wrstart.lat", 64'(lat), 33);
        chk("wrstart.res", {32'(hi), 32'(lo)}, m);

        // reset mid-operation aborts with no write and no done
        @(negedge CLK); op = 2'b11; srca = 32'd9; srcb = 32'd0; start = 1'b1;
        @(posedge CLK); #1; start = 1'b0;
        chk("rstmid.dz_set", 64'(dz), 1);
        repeat (10) @(posedge CLK);
        #1; RST = 1'b0; #1;
        chk("rstmid.busy", 64'(busy), 0);
        chk("rstmid.hilo", {32'(hi), 32'(lo)}, 0);
        chk("rstmid.done", 64'(done), 0);
        chk("rstmid.dz", 64'(dz), 0);
        @(negedge CLK); RST = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK); #1;
            if (done || busy) dones++;
        end
        chk("rstmid.quiet", 64'(dones), 0);
        run_op(2'b01, 32'd12345, -32'sd678, 1'b0, "post_rst");

        // randomized ops, biased toward operand corners
        for (int k = 0; k < 30; k++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: rb = 32'hFFFF_FFFF;
                2: rb = 32'($urandom_range(1, 15));
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            run_op(ro, ra, rb, 1'($urandom_range(0, 1)), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
